// File: rtl/window_gen.sv
// Builds 3x3 pixel neighbourhoods from a raster-ordered stream using two line buffers.
// A window is emitted only for interior pixels, i.e. row>=2 and col>=2.
module window_gen #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            axis_i_vld_i,
    input  logic [23:0]     axis_i_data_i,
    output logic            axis_i_rdy_o,
    output logic            axis_o_vld_o,
    output logic [9*24-1:0] axis_o_data_o,
    input  logic            axis_o_rdy_i
);

    localparam int PW = 24;
    localparam int CW = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Window element [i][j] occupies bits (i*3+j)*24 +: 24 of the output bus.
    logic [2:0][2:0][PW-1:0] w_q, w_d;
    logic [2:0][2:0][PW-1:0] data_q;
    logic                    vld_q;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;

    logic [PW-1:0] lb0 [WIDTH];
    logic [PW-1:0] lb1 [WIDTH];
    logic [PW-1:0] lb_a, lb_b;
    logic          accept;
    logic          emit;

    assign axis_i_rdy_o  = !vld_q || axis_o_rdy_i;
    assign accept        = axis_i_vld_i && axis_i_rdy_o;
    assign emit          = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign axis_o_vld_o  = vld_q;
    assign axis_o_data_o = data_q;

    always_comb begin
        lb_a = lb0[col_q];
        lb_b = lb1[col_q];
        w_d  = w_q;
        for (int i = 0; i < 3; i++) begin
            w_d[i][0] = w_q[i][1];
            w_d[i][1] = w_q[i][2];
        end
        w_d[0][2] = lb_b;
        w_d[1][2] = lb_a;
        w_d[2][2] = axis_i_data_i;
    end

    always_comb begin
        col_d = col_q + CW'(1);
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end
    end

    // Line buffer contents need no reset; they refill over the first two rows.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_q] <= lb_a;
            lb0[col_q] <= axis_i_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q    <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            if (accept) begin
                w_q   <= w_d;
                col_q <= col_d;
                row_q <= row_d;
            end
            if (accept && emit) begin
                vld_q  <= 1'b1;
                data_q <= w_d;
            end else if (vld_q && axis_o_rdy_i) begin
                vld_q <= 1'b0;
            end
        end
    end

endmodule
